alu_control_fsm: RTL

- Multicycle MIPS control unit. It drives the ALU's 4-bit operation select and consumes the ALU zero flag.
- It sequences fetch, decode, execute, memory and writeback.
- It generates all datapath enables and muxes for the shared-memory multicycle datapath.
- A retired-instruction counter and an illegal-instruction pulse are provided for debug and verification.

---
 rtl/alu_control_fsm.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// drives every datapath enable and mux, and keeps a retired-instruction count.
module alu_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [3:0]       alu_ctrl,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtEx   = 4'd6,
        StRtWb   = 4'd7,
        StBranch = 4'd8,
        StImmEx  = 4'd9,
        StImmWb  = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = StFetch;
        retire     = 1'b0;
        alu_ctrl   = 4'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_en     = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = 4'd2;
                state_d   = StDecode;
            end
            StDecode: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'b11;
                alu_ctrl  = 4'd2;
                case (opcode)
                    OpLw, OpSw:                   state_d = StMemAdr;
                    OpRtype:                      state_d = StRtEx;
                    OpBeq, OpBne:                 state_d = StBranch;
                    OpAddi, OpAndi, OpOri, OpSlti: state_d = StImmEx;
                    OpJ:                          state_d = StJump;
                    default:                      illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = 4'd2;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = StMemWb;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            StRtEx: begin
                alu_src_a = 1'b1;
                state_d   = StRtWb;
                case (funct)
                    6'h20:   alu_ctrl = 4'd2;
                    6'h22:   alu_ctrl = 4'd6;
                    6'h24:   alu_ctrl = 4'd0;
                    6'h25:   alu_ctrl = 4'd1;
                    6'h27:   alu_ctrl = 4'd12;
                    6'h2A:   alu_ctrl = 4'd7;
                    default: begin
                        alu_ctrl = 4'd2;
                        illegal  = 1'b1;
                        state_d  = StFetch;
                    end
                endcase
            end
            StRtWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 4'd6;
                pc_src    = 2'b01;
                pc_en     = (opcode == OpBne) ? ~zero : zero;
                retire    = 1'b1;
            end
            StImmEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StImmWb;
                case (opcode)
                    OpAndi:  begin alu_ctrl = 4'd0; ext_op = 1'b1; end
                    OpOri:   begin alu_ctrl = 4'd1; ext_op = 1'b1; end
                    OpSlti:  alu_ctrl = 4'd7;
                    default: alu_ctrl = 4'd2;
                endcase
            end
            StImmWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            StJump: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset kills every side effect immediately, not just at the next edge.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_en     = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule
